// File: rtl/load_store_unit_if.sv
// Bundle between the MEM-stage requester, the load/store unit and the
// word-addressed data memory.
//
// Handshake: a request transfers on the posedge where req_valid && req_ready
// are both 1. The requester holds every req_* signal stable until that edge.
// req_ready is not allowed to depend on req_valid. resp_valid is a one-cycle
// strobe with no backpressure; resp_rdata and resp_err are meaningful only
// while it is high. The memory returns ReadData combinationally while
// MemRead=1 and writes WriteData on the posedge where MemWrite=1.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       WriteData;
  logic [31:0]       ReadData;

  // Load/store unit side.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData
  );

  // Requester plus memory side.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time toward a word-addressed data memory.
// Byte and halfword loads are extracted with sign or zero extension.
// Byte and halfword stores use a read-modify-write sequence.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword and word
// accesses are rejected with resp_err. Without it, those accesses are
// force-aligned.
module load_store_unit #(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 16384
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // One bit wider than the word index, so the limit never truncates.
  localparam logic [ADDR_W-2:0] MEM_WORDS_L = (ADDR_W-1)'(MEM_WORDS);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        accept;
  logic        size_err, range_err, align_err, req_err;
  logic [1:0]  eff_off;
  logic [4:0]  sh;
  logic [31:0] shifted, load_val, lane_mask, merged;

  assign accept = bus.req_valid && (state_q == S_IDLE);

  // Classify the incoming request. No memory access is made for a rejected request.
  always_comb begin
    size_err  = (bus.req_size == 2'd3);
    range_err = ({1'b0, bus.req_addr[ADDR_W-1:2]} >= MEM_WORDS_L);
`ifdef LSU_MISALIGN_TRAP_EN
    align_err = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
`else
    align_err = 1'b0;
`endif
    req_err   = size_err || range_err || align_err;
  end

  // Lane selection, load extraction and the read-modify-write merge.
  always_comb begin
    eff_off = (size_q == 2'd1) ? {off_q[1], 1'b0} : off_q;
    sh      = {eff_off, 3'b000};
    shifted = bus.ReadData >> sh;
    case (size_q)
      2'd0:    load_val = sgn_q ? {{24{shifted[7]}}, shifted[7:0]}
                                : {24'h0, shifted[7:0]};
      2'd1:    load_val = sgn_q ? {{16{shifted[15]}}, shifted[15:0]}
                                : {16'h0, shifted[15:0]};
      default: load_val = bus.ReadData;
    endcase
    lane_mask = (size_q == 2'd0) ? (32'h0000_00ff << sh) : (32'h0000_ffff << sh);
    merged    = (bus.ReadData & ~lane_mask) | ((wdata_q << sh) & lane_mask);
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          off_d   = bus.req_addr[1:0];
          wdata_d = bus.req_wdata;
          rdata_d = 32'h0;
          err_d   = req_err;
          if (req_err) begin
            state_d = S_RESP;
          end else begin
            addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
            if (bus.req_write && (bus.req_size == 2'd2)) begin
              wr_data_d = bus.req_wdata;
              state_d   = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (write_q) begin
          wr_data_d = merged;
          state_d   = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_RESP;
        end
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Registers. Reset drops any in-flight request with no response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      size_q    <= 2'd0;
      sgn_q     <= 1'b0;
      off_q     <= 2'd0;
      wdata_q   <= 32'h0;
      addr_q    <= '0;
      wr_data_q <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Strobes are decoded from state only. This keeps MemWrite glitch-free and
  // makes it fall as soon as reset is asserted.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_err   = (state_q == S_RESP) && err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.MemRead    = (state_q == S_RD);
  assign bus.MemWrite   = (state_q == S_WR);
  assign bus.Address    = addr_q;
  assign bus.WriteData  = wr_data_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. A table of requests with hand-computed
// results is applied in a loop. Hand-written sequences cover reset and
// reset in the middle of a store.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;
  logic        pre_we;
  logic [13:0] pre_idx;
  logic [31:0] pre_val;
  logic [31:0] mem [0:16383];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .MEM_WORDS(16384)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Data memory model: combinational read, posedge write, plus a preload port.
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (bus.MemWrite) mem[bus.Address[15:2]] <= bus.WriteData;
  end
  assign bus.ReadData = bus.MemRead ? mem[bus.Address[15:2]] : 32'h0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic wr, logic [1:0] size, logic sgn,
                              logic [31:0] addr, logic [31:0] wdata,
                              logic pre, logic [31:0] pre_addr, logic [31:0] pre_data,
                              logic [31:0] exp_rdata, logic exp_err, int exp_lat,
                              int exp_rd, int exp_wr,
                              logic [31:0] exp_addr, logic [31:0] exp_word);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.pre = pre; v.pre_addr = pre_addr; v.pre_data = pre_data;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_addr = exp_addr; v.exp_word = exp_word;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = a[15:2];
    pre_val = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic drive_req(input vec_t v);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.wr;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat, nrd, nwr;
    logic [31:0] last_addr, last_wdata, got_rdata, exp_rd;
    logic        got_err;
    lat = 0; nrd = 0; nwr = 0;
    last_addr = 32'h0; last_wdata = 32'h0; got_rdata = 32'h0; got_err = 1'b0;
    if (v.pre) preload(v.pre_addr, v.pre_data);
    exp_q.push_back(v.exp_rdata);
    drive_req(v);
    chk($sformatf("v%0d_ready", idx), 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.MemRead) begin
        nrd++;
        last_addr = bus.Address;
      end
      if (bus.MemWrite) begin
        nwr++;
        last_addr  = bus.Address;
        last_wdata = bus.WriteData;
      end
      if (bus.resp_valid) begin
        lat       = c;
        got_rdata = bus.resp_rdata;
        got_err   = bus.resp_err;
        break;
      end
    end
    exp_rd = exp_q.pop_front();
    if (lat == 0) begin
      chk($sformatf("v%0d_resp_timeout", idx), 32'd0, 32'd1);
    end else begin
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_err", idx), 32'(got_err), 32'(v.exp_err));
      chk($sformatf("v%0d_rdata", idx), got_rdata, exp_rd);
      chk($sformatf("v%0d_memread_cycles", idx), 32'(nrd), 32'(v.exp_rd));
      chk($sformatf("v%0d_memwrite_cycles", idx), 32'(nwr), 32'(v.exp_wr));
      if (v.exp_rd + v.exp_wr > 0)
        chk($sformatf("v%0d_address", idx), last_addr, v.exp_addr);
      if (v.exp_wr > 0) begin
        chk($sformatf("v%0d_writedata", idx), last_wdata, v.exp_word);
        chk($sformatf("v%0d_mem_word", idx), mem[v.exp_addr[15:2]], v.exp_word);
      end
    end
  endtask

  initial begin
    vec_t rv;
    int   nresp;
    logic seen_wr;

    // Vector table: wr size sgn addr wdata | pre pre_addr pre_data |
    // exp_rdata err lat rd wr exp_addr exp_word
    vecs[0]  = mk(1, 2, 0, 32'h40, 32'hDEADBEEF, 0, 0, 0,
                  32'h0, 0, 2, 0, 1, 32'h40, 32'hDEADBEEF);
    vecs[1]  = mk(0, 2, 0, 32'h40, 32'h0, 0, 0, 0,
                  32'hDEADBEEF, 0, 2, 1, 0, 32'h40, 32'h0);
    vecs[2]  = mk(1, 0, 0, 32'h42, 32'h00000011, 1, 32'h40, 32'h8899AABB,
                  32'h0, 0, 3, 1, 1, 32'h40, 32'h8811AABB);
    vecs[3]  = mk(0, 0, 1, 32'h40, 32'h0, 1, 32'h40, 32'h80F0017F,
                  32'h0000007F, 0, 2, 1, 0, 32'h40, 32'h0);
    vecs[4]  = mk(0, 0, 1, 32'h43, 32'h0, 0, 0, 0,
                  32'hFFFFFF80, 0, 2, 1, 0, 32'h40, 32'h0);
    vecs[5]  = mk(0, 1, 0, 32'h42, 32'h0, 0, 0, 0,
                  32'h000080F0, 0, 2, 1, 0, 32'h40, 32'h0);
    vecs[6]  = mk(0, 1, 1, 32'h42, 32'h0, 0, 0, 0,
                  32'hFFFF80F0, 0, 2, 1, 0, 32'h40, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[7]  = mk(0, 2, 0, 32'h42, 32'h0, 0, 0, 0,
                  32'h0, 1, 1, 0, 0, 32'h0, 32'h0);
`else
    vecs[7]  = mk(0, 2, 0, 32'h42, 32'h0, 0, 0, 0,
                  32'h80F0017F, 0, 2, 1, 0, 32'h40, 32'h0);
`endif
    vecs[8]  = mk(0, 3, 0, 32'h40, 32'h0, 0, 0, 0,
                  32'h0, 1, 1, 0, 0, 32'h0, 32'h0);
    vecs[9]  = mk(0, 2, 0, 32'h10000, 32'h0, 0, 0, 0,
                  32'h0, 1, 1, 0, 0, 32'h0, 32'h0);
    vecs[10] = mk(1, 1, 0, 32'h46, 32'h1234CAFE, 1, 32'h44, 32'h11223344,
                  32'h0, 0, 3, 1, 1, 32'h44, 32'hCAFE3344);
    vecs[11] = mk(0, 0, 0, 32'h41, 32'h0, 0, 0, 0,
                  32'h00000001, 0, 2, 1, 0, 32'h40, 32'h0);
    vecs[12] = mk(0, 2, 0, 32'hFFFC, 32'h0, 1, 32'hFFFC, 32'h12345678,
                  32'h12345678, 0, 2, 1, 0, 32'hFFFC, 32'h0);
    vecs[13] = mk(1, 3, 0, 32'h44, 32'hFFFFFFFF, 0, 0, 0,
                  32'h0, 1, 1, 0, 0, 32'h0, 32'h0);

    // Reset state.
    rst_n = 1'b0;
    pre_we = 1'b0; pre_idx = 14'h0; pre_val = 32'h0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_memread", 32'(bus.MemRead), 32'd0);
    chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("rst_address", bus.Address, 32'h0);
    chk("rst_writedata", bus.WriteData, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Address and WriteData hold their last values while idle (after vector 13 error).
    @(negedge clk);
    chk("hold_address", bus.Address, 32'hFFFC);

    // Reset asserted during the WR cycle of a byte store.
    preload(32'h40, 32'h8899AABB);
    rv = mk(1, 0, 0, 32'h41, 32'h00000055, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_req(rv);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    seen_wr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.MemWrite) begin
        seen_wr = 1'b1;
        break;
      end
    end
    chk("mid_wr_reached", 32'(seen_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    nresp = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.resp_valid) nresp++;
    end
    chk("mid_rst_no_resp", 32'(nresp), 32'd0);
    chk("mid_rst_ready_after", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_mem_unchanged", mem[16], 32'h8899AABB);
    rv = mk(0, 2, 0, 32'h40, 32'h0, 0, 0, 0,
            32'h8899AABB, 0, 2, 1, 0, 32'h40, 32'h0);
    run_vec(rv, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Takes one load/store request at a time from the MEM pipeline stage.
- Drives MemRead, MemWrite, Address and WriteData toward the word-addressed data memory. The memory returns ReadData combinationally while MemRead=1 and writes on posedge clk.
- Adds byte and halfword access: loads are extracted with sign or zero extension; sub-word stores use a read-modify-write sequence.
- Returns the result through a single-cycle response strobe.

Parameters:
- ADDR_W, 32, width of req_addr and Address.
- MEM_WORDS, 16384, number of 32-bit words in the data memory; word indices at or above this are out of range.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present; the requester holds all req_* stable until accepted.
- req_ready  output  1  unit idle; request accepted on posedge when req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 = illegal.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; byte and halfword stores use the low lanes.
- resp_valid  output  1  one-cycle completion pulse; no backpressure.
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores.
- resp_err  output  1  request rejected, valid with resp_valid; no memory access was made.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable.
- Address  output  ADDR_W  word-aligned byte address; bits [1:0] always 0.
- WriteData  output  32  full word to be written.
- ReadData  input  32  memory read word.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=1.
  - resp_valid, resp_err, MemRead and MemWrite are 0.
  - Address, WriteData and resp_rdata are 0.
  - Any in-flight request is dropped with no response. MemWrite falls immediately.
- Byte lanes are little-endian: offset k maps to bits [8k+7:8k].
- State machine with registered state. MemRead and MemWrite are decoded from state only.
  - IDLE:
    - req_ready=1.
    - On acceptance, latch the request.
    - If the request is in error, go to RESP with resp_err=1.
    - Else a load goes to RD.
    - Else a word store goes to WR with WriteData=req_wdata.
    - Else (byte/halfword store) go to RD.
  - RD:
    - MemRead=1, Address = latched addr with [1:0] forced to 00.
    - At posedge, sample ReadData.
    - Load: select lane(s) by addr[1:0] and size, extend per req_signed into resp_rdata, go to RESP.
    - Sub-word store: WriteData = sampled word with the addressed byte/halfword replaced from req_wdata; go to WR.
  - WR: MemWrite=1 for exactly one cycle, then go to RESP.
  - RESP: resp_valid=1 for one cycle, then go to IDLE. req_ready=0.
- req_ready is 0 in every state except IDLE. req_valid while busy is ignored.
- Error conditions:
  - req_size=3.
  - Word index addr[ADDR_W-1:2] >= MEM_WORDS.
  - Misalignment (see Optional Feature).
- Latency from the acceptance edge to resp_valid high:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Throughput: a new request may be accepted in the cycle after RESP.
- Address and WriteData hold their last values outside RD/WR. The memory ignores them when MemRead and MemWrite are both 0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - halfword with addr[0]=1 is an error;
  - word with addr[1:0]!=0 is an error;
  - errors return resp_err=1 with no MemRead/MemWrite pulse.
- Undefined:
  - no misalignment errors;
  - halfword ignores addr[0];
  - word ignores addr[1:0];
  - access is force-aligned.
- Size and range errors apply in both builds.

Test Plan:
- Word store 0xDEADBEEF to 0x40, then word load from 0x40:
  - one MemWrite pulse with Address=0x40;
  - resp_rdata=0xDEADBEEF two cycles after acceptance.
- Memory word 0x40 = 0x8899AABB, byte store 0x11 to 0x42:
  - one RD cycle, then WR with WriteData=0x8811AABB;
  - resp_valid three cycles after acceptance.
- Memory word 0x40 = 0x80F0017F, loads:
  - signed byte at 0x40 gives 0x0000007F;
  - signed byte at 0x43 gives 0xFFFFFF80;
  - unsigned halfword at 0x42 gives 0x000080F0;
  - signed halfword at 0x42 gives 0xFFFF80F0.
- Word load at 0x42:
  - with LSU_MISALIGN_TRAP_EN: resp_err=1 one cycle after acceptance, MemRead never asserted;
  - without it: Address=0x40 and the full word is returned.
- req_size=3, and separately address 0x10000 with MEM_WORDS=16384: resp_err=1 with no memory strobes.
- rst_n low during the WR cycle of a byte store:
  - MemWrite drops immediately and no resp_valid follows;
  - req_ready=1 after release;
  - the next request completes normally.
